// File: rtl/tdm_demux.sv
// Time-division demultiplexer: splits an interleaved serial sample stream into
// CHANNELS lanes and presents each completed frame on a registered parallel bus.
//
// state   | meaning
// IDLE    | waiting for a start-of-frame sample; orphan samples are dropped
// COLLECT | frame in progress; sel is the lane the next sample lands in
module tdm_demux #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic                      in_sof,
   input  logic [WIDTH-1:0]          in_data,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic                      out_valid,
   output logic [SEL_W-1:0]          sel,
   output logic                      frame_err
);

   typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

   localparam int SH_W = (CHANNELS - 1) * WIDTH;
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);
   localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

   state_t                      state_q, state_d;
   logic [SEL_W-1:0]            sel_q, sel_d;
   logic [SH_W-1:0]             shadow_q, shadow_d;
   logic [CHANNELS*WIDTH-1:0]   out_data_q, out_data_d;
   logic                        out_valid_q, out_valid_d;
   logic                        frame_err_q, frame_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         shadow_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         shadow_q    <= shadow_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      shadow_d    = shadow_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      frame_err_d = 1'b0;

      if (in_valid) begin
         if (in_sof) begin
            // A sof always starts a fresh frame; in COLLECT it also aborts the old one.
            shadow_d[WIDTH-1:0] = in_data;
            sel_d               = SEL_ONE;
            state_d             = COLLECT;
            frame_err_d         = (state_q == COLLECT);
         end else if (state_q == COLLECT) begin
            if (sel_q == SEL_LAST) begin
               out_data_d  = {in_data, shadow_q};
               out_valid_d = 1'b1;
               sel_d       = '0;
               state_d     = IDLE;
            end else begin
               for (int k = 1; k < CHANNELS - 1; k++) begin
                  if (sel_q == SEL_W'(k)) begin
                     shadow_d[k*WIDTH +: WIDTH] = in_data;
                  end
               end
               sel_d = sel_q + SEL_ONE;
            end
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign sel       = sel_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed, table-driven bench for tdm_demux with hand-computed expectations
// plus a hand-written asynchronous mid-frame reset sequence.
module tb_tdm_demux;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_sof;
   logic [7:0]  in_data;
   logic [31:0] out_data;
   logic        out_valid;
   logic [1:0]  sel;
   logic        frame_err;

   int n_cmp = 0;
   int n_err = 0;

   tdm_demux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_data   (in_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .sel       (sel),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        s;
      logic [7:0]  d;
      logic [31:0] od;
      logic        ov;
      logic [1:0]  sl;
      logic        er;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic v, input logic s, input logic [7:0] d,
                               input logic [31:0] od, input logic ov,
                               input logic [1:0] sl, input logic er);
      vec_t t;
      t.v = v; t.s = s; t.d = d; t.od = od; t.ov = ov; t.sl = sl; t.er = er;
      vq.push_back(t);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic [31:0] od, input logic ov,
                          input logic [1:0] sl, input logic er);
      chk("out_data", idx, out_data, od);
      chk("out_valid", idx, 32'(out_valid), 32'(ov));
      chk("sel", idx, 32'(sel), 32'(sl));
      chk("frame_err", idx, 32'(frame_err), 32'(er));
   endtask

   task automatic drive(input logic v, input logic s, input logic [7:0] d);
      @(negedge clk);
      in_valid = v;
      in_sof   = s;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = 8'h00;

      // Basic frame
      add(1, 1, 8'h11, 32'h0,        0, 2'd1, 0);
      add(1, 0, 8'h22, 32'h0,        0, 2'd2, 0);
      add(1, 0, 8'h33, 32'h0,        0, 2'd3, 0);
      add(1, 0, 8'h44, 32'h44332211, 1, 2'd0, 0);
      add(0, 0, 8'h99, 32'h44332211, 0, 2'd0, 0);
      // Gapped frame, including sof while in_valid=0
      add(1, 1, 8'h11, 32'h44332211, 0, 2'd1, 0);
      add(0, 1, 8'hEE, 32'h44332211, 0, 2'd1, 0);
      add(0, 0, 8'hEE, 32'h44332211, 0, 2'd1, 0);
      add(1, 0, 8'h22, 32'h44332211, 0, 2'd2, 0);
      add(0, 0, 8'h00, 32'h44332211, 0, 2'd2, 0);
      add(0, 0, 8'h00, 32'h44332211, 0, 2'd2, 0);
      add(1, 0, 8'h33, 32'h44332211, 0, 2'd3, 0);
      add(0, 1, 8'h77, 32'h44332211, 0, 2'd3, 0);
      add(0, 0, 8'h77, 32'h44332211, 0, 2'd3, 0);
      add(1, 0, 8'h44, 32'h44332211, 1, 2'd0, 0);
      add(0, 0, 8'h00, 32'h44332211, 0, 2'd0, 0);
      // Orphan, sof with in_valid=0 while idle, then early sof
      add(1, 0, 8'h55, 32'h44332211, 0, 2'd0, 0);
      add(0, 1, 8'h66, 32'h44332211, 0, 2'd0, 0);
      add(1, 1, 8'hA1, 32'h44332211, 0, 2'd1, 0);
      add(1, 0, 8'hA2, 32'h44332211, 0, 2'd2, 0);
      add(1, 1, 8'hB1, 32'h44332211, 0, 2'd1, 1);
      add(1, 0, 8'hB2, 32'h44332211, 0, 2'd2, 0);
      add(1, 0, 8'hB3, 32'h44332211, 0, 2'd3, 0);
      add(1, 0, 8'hB4, 32'hB4B3B2B1, 1, 2'd0, 0);
      // Early sof at the last lane
      add(1, 1, 8'hC1, 32'hB4B3B2B1, 0, 2'd1, 0);
      add(1, 0, 8'hC2, 32'hB4B3B2B1, 0, 2'd2, 0);
      add(1, 0, 8'hC3, 32'hB4B3B2B1, 0, 2'd3, 0);
      add(1, 1, 8'hD1, 32'hB4B3B2B1, 0, 2'd1, 1);
      add(0, 0, 8'h00, 32'hB4B3B2B1, 0, 2'd1, 0);
      add(1, 0, 8'hD2, 32'hB4B3B2B1, 0, 2'd2, 0);
      add(1, 0, 8'hD3, 32'hB4B3B2B1, 0, 2'd3, 0);
      add(1, 0, 8'hD4, 32'hD4D3D2D1, 1, 2'd0, 0);
      // Back-to-back frames
      add(1, 1, 8'h01, 32'hD4D3D2D1, 0, 2'd1, 0);
      add(1, 0, 8'h02, 32'hD4D3D2D1, 0, 2'd2, 0);
      add(1, 0, 8'h03, 32'hD4D3D2D1, 0, 2'd3, 0);
      add(1, 0, 8'h04, 32'h04030201, 1, 2'd0, 0);
      add(1, 1, 8'h05, 32'h04030201, 0, 2'd1, 0);
      add(1, 0, 8'h06, 32'h04030201, 0, 2'd2, 0);
      add(1, 0, 8'h07, 32'h04030201, 0, 2'd3, 0);
      add(1, 0, 8'h08, 32'h08070605, 1, 2'd0, 0);
      add(0, 0, 8'h00, 32'h08070605, 0, 2'd0, 0);

      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'($urandom_range(0, 1));
         in_sof   = 1'($urandom_range(0, 1));
         in_data  = 8'($urandom);
         @(posedge clk);
         #1;
         chk_all(100 + i, 32'h0, 0, 2'd0, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      rst_n    = 1'b1;

      foreach (vq[i]) begin
         drive(vq[i].v, vq[i].s, vq[i].d);
         chk_all(i, vq[i].od, vq[i].ov, vq[i].sl, vq[i].er);
      end

      // Async reset mid-frame: assert between edges, outputs clear with no clock
      drive(1, 1, 8'h31);
      drive(1, 0, 8'h32);
      chk_all(200, 32'h08070605, 0, 2'd2, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all(201, 32'h0, 0, 2'd0, 0);
      drive(1, 0, 8'h33);
      chk_all(202, 32'h0, 0, 2'd0, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      drive(1, 0, 8'h34);
      chk_all(203, 32'h0, 0, 2'd0, 0);
      drive(1, 1, 8'hAA);
      chk_all(204, 32'h0, 0, 2'd1, 0);
      drive(1, 0, 8'hBB);
      chk_all(205, 32'h0, 0, 2'd2, 0);
      drive(1, 0, 8'hCC);
      chk_all(206, 32'h0, 0, 2'd3, 0);
      drive(1, 0, 8'hDD);
      chk_all(207, 32'hDDCCBBAA, 1, 2'd0, 0);
      drive(0, 0, 8'h00);
      chk_all(208, 32'hDDCCBBAA, 0, 2'd0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
